// File: rtl/ram_arb2.sv
// Round-robin arbiter sharing one synchronous RAM between two masters.
// Bounded lock lets a master hold the RAM for short bursts.
module ram_arb2 #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic [DATA_W-1:0] ram_write_data,
  output logic              ram_read_en,
  output logic [ADDR_W-1:0] ram_read_addr,
  input  logic [DATA_W-1:0] ram_read_data
);

  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_HOLD);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic             last_q, last_d;
  logic             lk_q, lk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             pend_id_q, pend_id_d;
  logic             pend_err_q, pend_err_d;
  logic [1:0]       werr_q, werr_d;

  logic              gnt_any, gsel, hold;
  logic              sel_we, sel_lock, addr_ok;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Arbitration and selection of the winning master's request
  always_comb begin
    hold    = lk_q && (cnt_q < MAX_CNT);
    gsel    = 1'b0;
    if (m0_req && m1_req) gsel = hold ? last_q : ~last_q;
    else                  gsel = m1_req;
    gnt_any   = rst_n && (m0_req || m1_req);
    sel_we    = gsel ? m1_we    : m0_we;
    sel_lock  = gsel ? m1_lock  : m0_lock;
    sel_addr  = gsel ? m1_addr  : m0_addr;
    sel_wdata = gsel ? m1_wdata : m0_wdata;
    addr_ok   = {1'b0, sel_addr} < DEPTH_X;
  end

  assign m0_gnt         = gnt_any & ~gsel;
  assign m1_gnt         = gnt_any & gsel;
  assign ram_write_en   = gnt_any & sel_we & addr_ok;
  assign ram_write_addr = sel_addr;
  assign ram_write_data = sel_wdata;
  assign ram_read_en    = gnt_any & ~sel_we & addr_ok;
  assign ram_read_addr  = sel_addr;

  always_comb begin
    last_d     = last_q;
    lk_d       = 1'b0;
    cnt_d      = '0;
    pend_d     = 1'b0;
    pend_id_d  = pend_id_q;
    pend_err_d = 1'b0;
    werr_d     = 2'b00;
    if (gnt_any) begin
      last_d = gsel;
      lk_d   = sel_lock;
      if (gsel == last_q) cnt_d = (cnt_q == MAX_CNT) ? MAX_CNT : cnt_q + CNT_W'(1);
      else                cnt_d = CNT_W'(1);
      if (sel_we) begin
        if (!addr_ok) werr_d[gsel] = 1'b1;
      end else begin
        pend_d     = 1'b1;
        pend_id_d  = gsel;
        pend_err_d = ~addr_ok;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= 1'b1;
      lk_q       <= 1'b0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_id_q  <= 1'b0;
      pend_err_q <= 1'b0;
      werr_q     <= 2'b00;
    end else begin
      last_q     <= last_d;
      lk_q       <= lk_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_id_q  <= pend_id_d;
      pend_err_q <= pend_err_d;
      werr_q     <= werr_d;
    end
  end

  // Read return: RAM output is already registered, so it lines up with pend_q
  assign m0_rvalid = pend_q & ~pend_id_q;
  assign m1_rvalid = pend_q & pend_id_q;
  assign m0_err    = (m0_rvalid & pend_err_q) | werr_q[0];
  assign m1_err    = (m1_rvalid & pend_err_q) | werr_q[1];
  assign m0_rdata  = (m0_rvalid && !pend_err_q) ? ram_read_data : '0;
  assign m1_rdata  = (m1_rvalid && !pend_err_q) ? ram_read_data : '0;

endmodule

// File: tb/tb_ram_arb2.sv
// Directed bench for ram_arb2 with a behavioural 8x4 RAM and a return scoreboard.
module tb_ram_arb2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [7:0] m0_addr, m1_addr;
  logic [3:0] m0_wdata, m1_wdata;
  logic       m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [3:0] m0_rdata, m1_rdata;
  logic       ram_write_en, ram_read_en;
  logic [7:0] ram_write_addr, ram_read_addr;
  logic [3:0] ram_write_data, ram_read_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       id;
    logic       rd;
    logic [3:0] data;
    logic       err;
  } exp_t;
  exp_t sbq[$];

  logic [3:0] mem[8];
  logic [3:0] shadow[8];

  always #5 clk = ~clk;

  ram_arb2 dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_write_en(ram_write_en), .ram_write_addr(ram_write_addr), .ram_write_data(ram_write_data),
    .ram_read_en(ram_read_en), .ram_read_addr(ram_read_addr), .ram_read_data(ram_read_data)
  );

  // Behavioural RAM: one write port, registered read port
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_write_addr[2:0]] <= ram_write_data;
    if (ram_read_en)  ram_read_data <= mem[ram_read_addr[2:0]];
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ret();
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("m0_rvalid", {7'd0, m0_rvalid}, {7'd0, e.rd && !e.id});
      chk("m1_rvalid", {7'd0, m1_rvalid}, {7'd0, e.rd && e.id});
      chk("m0_err", {7'd0, m0_err}, {7'd0, e.err && !e.id});
      chk("m1_err", {7'd0, m1_err}, {7'd0, e.err && e.id});
      if (e.rd) chk(e.id ? "m1_rdata" : "m0_rdata", {4'd0, e.id ? m1_rdata : m0_rdata}, {4'd0, e.data});
    end else begin
      chk("idle_rvalid", {6'd0, m1_rvalid, m0_rvalid}, 8'd0);
      chk("idle_err", {6'd0, m1_err, m0_err}, 8'd0);
    end
  endtask

  task automatic step(input logic r0, input logic w0, input logic l0, input logic [7:0] a0,
                      input logic [3:0] d0, input logic r1, input logic w1, input logic l1,
                      input logic [7:0] a1, input logic [3:0] d1, input logic eg0, input logic eg1);
    logic       gw, ok;
    logic [7:0] ga;
    logic [3:0] gd;
    exp_t       e;
    m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
    #2;
    chk("m0_gnt", {7'd0, m0_gnt}, {7'd0, eg0});
    chk("m1_gnt", {7'd0, m1_gnt}, {7'd0, eg1});
    if (eg0 || eg1) begin
      gw = eg1 ? w1 : w0;
      ga = eg1 ? a1 : a0;
      gd = eg1 ? d1 : d0;
      ok = ga < 8'd8;
      chk("ram_write_en", {7'd0, ram_write_en}, {7'd0, gw && ok});
      chk("ram_read_en", {7'd0, ram_read_en}, {7'd0, !gw && ok});
      if (gw && ok) begin
        chk("ram_write_addr", ram_write_addr, ga);
        chk("ram_write_data", {4'd0, ram_write_data}, {4'd0, gd});
        shadow[ga[2:0]] = gd;
      end
      if (!gw && ok) chk("ram_read_addr", ram_read_addr, ga);
      if (!gw || !ok) begin
        e.id   = eg1;
        e.rd   = !gw;
        e.data = ok ? shadow[ga[2:0]] : 4'd0;
        e.err  = !ok;
        sbq.push_back(e);
      end
    end else begin
      chk("strobes_idle", {6'd0, ram_read_en, ram_write_en}, 8'd0);
    end
    @(posedge clk); #1;
    check_ret();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      mem[i] = 4'd0;
      shadow[i] = 4'd0;
    end
    rst_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_lock = 1'b0; m0_addr = 8'd3; m0_wdata = 4'hA;
    m1_req = 1'b1; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = 8'd5; m1_wdata = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state with requests pending
    chk("rst_gnt", {6'd0, m1_gnt, m0_gnt}, 8'd0);
    chk("rst_strobes", {6'd0, ram_read_en, ram_write_en}, 8'd0);
    chk("rst_rvalid", {6'd0, m1_rvalid, m0_rvalid}, 8'd0);
    chk("rst_err", {6'd0, m1_err, m0_err}, 8'd0);
    chk("rst_rdata", {m1_rdata, m0_rdata}, 8'd0);
    rst_n = 1'b1;

    // m0 write then read-back of the same address
    step(1, 1, 0, 8'd3, 4'hA, 0, 0, 0, 8'd0, 4'h0, 1, 0);
    step(1, 0, 0, 8'd3, 4'h0, 0, 0, 0, 8'd0, 4'h0, 1, 0);
    step(0, 0, 0, 8'd0, 4'h0, 0, 0, 0, 8'd0, 4'h0, 0, 0);
    step(0, 0, 0, 8'd0, 4'h0, 1, 1, 0, 8'd5, 4'h6, 0, 1);

    // Continuous contention without lock alternates
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 8'd3, 4'h0, 1, 0, 0, 8'd5, 4'h0, 1, 0);
      step(1, 0, 0, 8'd3, 4'h0, 1, 0, 0, 8'd5, 4'h0, 0, 1);
    end

    // m1 locks: once it wins it keeps the RAM MAX_HOLD cycles
    step(1, 0, 0, 8'd3, 4'h0, 1, 0, 1, 8'd5, 4'h0, 1, 0);
    repeat (4) step(1, 0, 0, 8'd3, 4'h0, 1, 0, 1, 8'd5, 4'h0, 0, 1);
    step(1, 0, 0, 8'd3, 4'h0, 1, 0, 1, 8'd5, 4'h0, 1, 0);

    // Lock dropped by owner hands over immediately
    step(1, 0, 0, 8'd3, 4'h0, 1, 0, 1, 8'd5, 4'h0, 0, 1);
    step(1, 0, 0, 8'd3, 4'h0, 1, 0, 0, 8'd5, 4'h0, 0, 1);
    step(1, 0, 0, 8'd3, 4'h0, 1, 0, 0, 8'd5, 4'h0, 1, 0);

    // Address boundaries: last legal entry, then out of range
    step(1, 1, 0, 8'd7, 4'hF, 0, 0, 0, 8'd0, 4'h0, 1, 0);
    step(1, 0, 0, 8'd7, 4'h0, 0, 0, 0, 8'd0, 4'h0, 1, 0);
    step(1, 1, 0, 8'd9, 4'h5, 0, 0, 0, 8'd0, 4'h0, 1, 0);
    step(1, 0, 0, 8'd9, 4'h0, 0, 0, 0, 8'd0, 4'h0, 1, 0);
    step(0, 0, 0, 8'd0, 4'h0, 1, 0, 0, 8'd8, 4'h0, 0, 1);
    step(1, 0, 0, 8'd7, 4'h0, 0, 0, 0, 8'd0, 4'h0, 1, 0);

    // Reset asserted after a read grant, before the capturing edge
    m0_req = 1'b1; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = 8'd3;
    m1_req = 1'b0;
    #2;
    chk("pre_rst_gnt", {7'd0, m0_gnt}, 8'd1);
    rst_n = 1'b0;
    #1;
    chk("in_rst_gnt", {6'd0, m1_gnt, m0_gnt}, 8'd0);
    chk("in_rst_strobes", {6'd0, ram_read_en, ram_write_en}, 8'd0);
    m0_req = 1'b0;
    @(posedge clk); #1;
    chk("in_rst_rvalid", {6'd0, m1_rvalid, m0_rvalid}, 8'd0);
    rst_n = 1'b1;
    step(0, 0, 0, 8'd0, 4'h0, 0, 0, 0, 8'd0, 4'h0, 0, 0);
    step(1, 0, 0, 8'd3, 4'h0, 1, 0, 0, 8'd5, 4'h0, 1, 0);
    step(0, 0, 0, 8'd0, 4'h0, 0, 0, 0, 8'd0, 4'h0, 0, 0);

    chk("sb_drained", 8'(sbq.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arb2.md
# ram_arb2

Two-requester round-robin arbiter that shares the single 8x4 synchronous RAM block (one write port, one registered read port) between two masters. It accepts at most one access per cycle, drives the RAM's write/read strobes, and returns read data to the originating master with a valid strobe. A bounded lock lets a master keep the RAM for a short burst. It sits between the two client blocks and the RAM instance.

## Interface
- DEPTH, 8, number of RAM entries; legal addresses 0..DEPTH-1
- ADDR_W, 8, address width (matches RAM port)
- DATA_W, 4, data width (matches RAM port)
- MAX_HOLD, 4, max consecutive locked grants to one master while the other waits (>=1)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- mN_req  in  1  master N (N=0,1) requests an access this cycle
- mN_we  in  1  1 = write, 0 = read
- mN_lock  in  1  request to keep priority on next cycle
- mN_addr  in  ADDR_W  access address
- mN_wdata  in  DATA_W  write data
- mN_gnt  out  1  combinational; access accepted this cycle
- mN_rvalid  out  1  registered; read data for master N valid this cycle
- mN_rdata  out  DATA_W  read data, meaningful only with mN_rvalid
- mN_err  out  1  registered; pulses with mN_rvalid, or the cycle after a write grant, when address was >= DEPTH
- ram_write_en  out  1  to RAM write_en
- ram_write_addr  out  ADDR_W
- ram_write_data  out  DATA_W
- ram_read_en  out  1  to RAM read_en
- ram_read_addr  out  ADDR_W
- ram_read_data  in  DATA_W  RAM registered read output

## Operation
- State: last (master granted most recently, reset 1 so m0 wins first contention), cnt (0..MAX_HOLD, reset 0), lk (lock flag of last grant, reset 0), pend/pend_id/pend_err (read return pipeline, reset 0).
- Grant: only one requester -> grant it. Both requesting -> grant last if lk=1 and cnt<MAX_HOLD; otherwise grant the master != last.
- On grant to master g: last<=g; lk<=mg_lock; cnt<=(g==last)?min(cnt+1,MAX_HOLD):1. Cycle with no grant: lk<=0, cnt<=0, last unchanged.
- Granted write, addr<DEPTH: ram_write_en=1, addr/data forwarded same cycle. Addr>=DEPTH: ram_write_en=0, mg_err pulses next cycle, no rvalid.
- Granted read, addr<DEPTH: ram_read_en=1, ram_read_addr=addr; pend<=1, pend_id<=g, pend_err<=0. Addr>=DEPTH: ram_read_en=0, pend<=1, pend_err<=1.
- Return: when pend=1, m[pend_id]_rvalid=1, rdata=pend_err?0:ram_read_data, err=pend_err. Other master's rvalid=0.
- Write and read strobes never both 1 in one cycle. Ungranted master must hold its request stable (no internal buffering).
- Write-then-read same address on consecutive cycles returns the new data.

## Timing
- Reset values: all gnt/rvalid/err = 0, ram_write_en = ram_read_en = 0, rdata = 0; RAM strobes low while rst_n=0.
- Grant latency 0 (same cycle as req). Read latency 1: grant at edge N, rvalid/rdata in cycle after edge N.
- Back-to-back reads from alternating masters: one return per cycle, in grant order.
- Reset asserted mid-read: pending return dropped, no rvalid after release.
- Lock dropped by owner: next contention grants the other master immediately.

## Test plan
- Reset, m0 writes 0xA to addr 3, then reads addr 3 -> m0_gnt each cycle, m0_rvalid one cycle after read grant, m0_rdata=0xA, m1_rvalid=0.
- Both req reads continuously, no lock -> grants alternate m0,m1,m0,...; rvalid alternates matching ids one cycle later.
- m1 holds req+lock, m0 req continuously, MAX_HOLD=4 -> m1 granted 4 consecutive cycles after winning, then m0 granted.
- m0 write addr 9 data 0x5, then read addr 9 -> ram_write_en=0, ram_read_en=0, m0_err pulses after each, read returns rvalid=1 rdata=0.
- m0 read granted, rst_n pulled low before next edge -> no m0_rvalid after reset; first post-reset contention grants m0.
